// File: rtl/pipe_run_controller_if.sv
// Program-load handshake between the host and pipe_run_controller.
// The host (master) offers one instruction byte per cycle with valid;
// the controller (slave) accepts it on a cycle where ready is also high.
interface pipe_run_controller_if;
    logic       valid;
    logic       ready;
    logic [7:0] data;
    logic       last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/pipe_run_controller.sv
// pipe_run_controller: load / flush / run / halt sequencer for the 8-bit
// four-stage datapath. Program bytes arrive over the ld interface and are
// written to instruction memory one cycle after acceptance. The core is held
// in reset through load and flush, released for exactly the sampled budget,
// then frozen through its clock enable so register contents can be read.
//
// Build option PIPE_RUN_CHECKSUM_EN: when defined, checksum carries the
// mod-256 sum of the bytes accepted in the current load; otherwise it is 0.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | after reset; core held in reset, waiting for start
// LOAD  | accepting program bytes, writing instruction memory
// FLUSH | core held in reset FLUSH_CYCLES cycles after the last write
// RUN   | core released, counting cycles up to the budget
// DONE  | core frozen (clock enable low), waiting for next start
module pipe_run_controller #(
    parameter int IMEM_DEPTH   = 64,
    parameter int ADDR_W       = 6,
    parameter int CYC_W        = 16,
    parameter int FLUSH_CYCLES = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [CYC_W-1:0]    run_budget,
    pipe_run_controller_if.slave ld,
    output logic                imem_we,
    output logic [ADDR_W-1:0]   imem_addr,
    output logic [7:0]          imem_wdata,
    output logic                core_reset_n,
    output logic                core_clk_en,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [ADDR_W:0]     load_count,
    output logic [CYC_W-1:0]    cycle_count,
    output logic [2:0]          state,
    output logic [7:0]          checksum
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_FLUSH = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Flush timer is a down-counter loaded with FLUSH_CYCLES-1 while loading.
    localparam int FL_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FL_W-1:0]   FLUSH_LOAD = FL_W'(FLUSH_CYCLES - 1);
    localparam logic [ADDR_W:0]   DEPTH_LAST = (ADDR_W + 1)'(IMEM_DEPTH - 1);

    state_t            cur_state;
    state_t            nxt_state;
    logic [CYC_W-1:0]  budget;
    logic [FL_W-1:0]   flush_cnt;
    logic              xfer;
    logic              start_ok;
    logic              budget_zero;
    logic              run_end;
    logic              in_busy;

    assign xfer        = (cur_state == S_LOAD) && ld.valid;
    assign start_ok    = start && !abort &&
                         ((cur_state == S_IDLE) || (cur_state == S_DONE));
    assign budget_zero = (run_budget == '0);
    assign run_end     = (cycle_count == (budget - 1'b1));
    assign in_busy     = (cur_state == S_LOAD) || (cur_state == S_FLUSH) ||
                         (cur_state == S_RUN);

    assign ld.ready     = (cur_state == S_LOAD);
    assign busy         = in_busy;
    assign done         = (cur_state == S_DONE);
    assign core_reset_n = (cur_state == S_RUN) || (cur_state == S_DONE);
    assign core_clk_en  = (cur_state != S_DONE);
    assign state        = cur_state;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cur_state <= S_IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Next-state decode; abort dominates every other exit from a busy state.
    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            S_IDLE, S_DONE: begin
                if (start_ok && !budget_zero) nxt_state = S_LOAD;
            end
            S_LOAD: begin
                if (abort) begin
                    nxt_state = S_DONE;
                end else if (xfer && (ld.last || (load_count == DEPTH_LAST))) begin
                    nxt_state = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (abort) begin
                    nxt_state = S_DONE;
                end else if (flush_cnt == '0) begin
                    nxt_state = S_RUN;
                end
            end
            S_RUN: begin
                if (abort || run_end) nxt_state = S_DONE;
            end
            default: nxt_state = S_IDLE;
        endcase
    end

    // Memory write pipeline, counters, budget latch and sticky error.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            imem_we     <= 1'b0;
            imem_addr   <= '0;
            imem_wdata  <= '0;
            load_count  <= '0;
            cycle_count <= '0;
            budget      <= '0;
            flush_cnt   <= '0;
            err         <= 1'b0;
        end else begin
            imem_we <= xfer;
            if (xfer) begin
                imem_addr  <= load_count[ADDR_W-1:0];
                imem_wdata <= ld.data;
                load_count <= load_count + 1'b1;
            end

            if (start_ok) begin
                if (budget_zero) begin
                    err <= 1'b1;
                end else begin
                    budget      <= run_budget;
                    load_count  <= '0;
                    cycle_count <= '0;
                    err         <= 1'b0;
                end
            end

            if (abort && in_busy) err <= 1'b1;

            if (cur_state == S_LOAD) begin
                flush_cnt <= FLUSH_LOAD;
            end else if ((cur_state == S_FLUSH) && (flush_cnt != '0)) begin
                flush_cnt <= flush_cnt - 1'b1;
            end

            // The last run cycle leaves the count at budget-1; abort freezes it.
            if ((cur_state == S_RUN) && !abort && !run_end) begin
                cycle_count <= cycle_count + 1'b1;
            end
        end
    end

`ifdef PIPE_RUN_CHECKSUM_EN
    // Running mod-256 sum of accepted program bytes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            checksum <= '0;
        end else if (start_ok && !budget_zero) begin
            checksum <= '0;
        end else if (xfer) begin
            checksum <= checksum + ld.data;
        end
    end
`else
    assign checksum = 8'h00;
`endif

endmodule

// File: tb/tb_pipe_run_controller.sv
// Self-checking bench for pipe_run_controller: directed scenarios plus
// randomized programs, compared against a transaction-level model of the
// load/flush/run sequence.
module tb_pipe_run_controller;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;
    localparam int CYC_W  = 16;
    localparam int FLUSH  = 3;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [CYC_W-1:0]  run_budget = '0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [7:0]        imem_wdata;
    logic              core_reset_n;
    logic              core_clk_en;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   load_count;
    logic [CYC_W-1:0]  cycle_count;
    logic [2:0]        state;
    logic [7:0]        checksum;

    pipe_run_controller_if ld_if ();

    pipe_run_controller #(
        .IMEM_DEPTH(DEPTH), .ADDR_W(ADDR_W), .CYC_W(CYC_W), .FLUSH_CYCLES(FLUSH)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .run_budget(run_budget), .ld(ld_if),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_reset_n(core_reset_n), .core_clk_en(core_clk_en),
        .busy(busy), .done(done), .err(err), .load_count(load_count),
        .cycle_count(cycle_count), .state(state), .checksum(checksum)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [7:0]        wr_data_q[$];
    int                flush_seen;
    int                run_seen;

    logic [7:0] prog_d[$];
    bit         prog_l[$];
    int         prog_g[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock; samples 1 time unit after the edge. A write must appear
    // exactly on the cycle after a handshake and on no other cycle.
    task automatic tick();
        logic exp_we;
        exp_we = ld_if.valid && ld_if.ready;
        @(posedge clock);
        #1;
        check("we_timing", {31'd0, imem_we}, {31'd0, exp_we});
        if (imem_we) begin
            wr_addr_q.push_back(imem_addr);
            wr_data_q.push_back(imem_wdata);
        end
        if (state == 3'd2) flush_seen++;
        if (core_reset_n && core_clk_en) run_seen++;
    endtask

    // Load ends on the first byte marked last, or at the DEPTH-th byte.
    function automatic int model_accepted();
        for (int i = 0; i < prog_d.size(); i++) begin
            if (prog_l[i] || i == DEPTH - 1) return i + 1;
        end
        return prog_d.size();
    endfunction

    function automatic logic [7:0] model_sum(input int n);
        int s;
        s = 0;
        for (int i = 0; i < n; i++) s = s + int'(prog_d[i]);
        return 8'(s % 256);
    endfunction

    task automatic clear_prog();
        prog_d.delete();
        prog_l.delete();
        prog_g.delete();
    endtask

    task automatic add_byte(input logic [7:0] d, input bit l, input int g);
        prog_d.push_back(d);
        prog_l.push_back(l);
        prog_g.push_back(g);
    endtask

    // Full load/flush/run pass. abort_at >= 0 raises abort in RUN when
    // cycle_count shows that value.
    task automatic run_program(input int budget, input int abort_at);
        int         n_exp;
        int         n_chk;
        logic [7:0] sum_exp;
        n_exp   = model_accepted();
        sum_exp = model_sum(n_exp);
        wr_addr_q.delete();
        wr_data_q.delete();
        flush_seen = 0;
        run_seen   = 0;

        run_budget = CYC_W'(budget);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_state", 32'(state), 32'd1);
        check("start_err", 32'(err), 32'd0);
        check("start_lcnt", 32'(load_count), 32'd0);
        check("start_ready", 32'(ld_if.ready), 32'd1);

        for (int i = 0; i < prog_d.size(); i++) begin
            ld_if.valid = 1'b0;
            repeat (prog_g[i]) tick();
            ld_if.valid = 1'b1;
            ld_if.data  = prog_d[i];
            ld_if.last  = prog_l[i];
            if (!ld_if.ready) begin
                tick();
                break;
            end
            tick();
        end
        ld_if.valid = 1'b0;
        ld_if.last  = 1'b0;

        for (int g = 0; g < budget + FLUSH + 20 && state != 3'd4; g++) begin
            if (abort_at >= 0 && state == 3'd3 && int'(cycle_count) == abort_at) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
            end else begin
                tick();
            end
        end

        check("reach_done", 32'(state), 32'd4);
        check("wr_count", 32'(wr_addr_q.size()), 32'(n_exp));
        n_chk = (wr_addr_q.size() < n_exp) ? wr_addr_q.size() : n_exp;
        for (int i = 0; i < n_chk; i++) begin
            check("wr_addr", 32'(wr_addr_q[i]), 32'(i));
            check("wr_data", 32'(wr_data_q[i]), 32'(prog_d[i]));
        end
        check("load_count", 32'(load_count), 32'(n_exp));
        check("done", 32'(done), 32'd1);
        check("busy_done", 32'(busy), 32'd0);
        check("clk_en_done", 32'(core_clk_en), 32'd0);
        check("rst_n_done", 32'(core_reset_n), 32'd1);
`ifdef PIPE_RUN_CHECKSUM_EN
        check("checksum", 32'(checksum), 32'(sum_exp));
`else
        check("checksum", 32'(checksum), 32'd0);
`endif
        if (abort_at < 0) begin
            check("flush_len", 32'(flush_seen), 32'(FLUSH));
            check("run_cycles", 32'(run_seen), 32'(budget));
            check("cycle_count", 32'(cycle_count), 32'(budget - 1));
            check("err_clean", 32'(err), 32'd0);
        end else begin
            check("abort_err", 32'(err), 32'd1);
            check("abort_cc", 32'(int'(cycle_count) == abort_at ||
                                  int'(cycle_count) == abort_at + 1), 32'd1);
        end
    endtask

    // Reset values of every output.
    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, 32'(state), 32'd0);
        check({tag, "_ready"}, 32'(ld_if.ready), 32'd0);
        check({tag, "_we"}, 32'(imem_we), 32'd0);
        check({tag, "_addr"}, 32'(imem_addr), 32'd0);
        check({tag, "_wdata"}, 32'(imem_wdata), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_lcnt"}, 32'(load_count), 32'd0);
        check({tag, "_ccnt"}, 32'(cycle_count), 32'd0);
        check({tag, "_csum"}, 32'(checksum), 32'd0);
        check({tag, "_rst_n"}, 32'(core_reset_n), 32'd0);
        check({tag, "_clk_en"}, 32'(core_clk_en), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int len;
        int budget;
        int abort_at;
        int early_pos;
        bit early_en;
        bit cap_run;

        ld_if.valid = 1'b0;
        ld_if.data  = 8'h00;
        ld_if.last  = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_reset_values("rst");
        reset = 1'b1;
        tick();

        // Zero budget rejected; start together with abort does nothing.
        run_budget = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("zb_state", 32'(state), 32'd0);
        check("zb_err", 32'(err), 32'd1);
        check("zb_ready", 32'(ld_if.ready), 32'd0);
        run_budget = 16'd5;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("sa_state", 32'(state), 32'd0);
        check("sa_err", 32'(err), 32'd1);

        // Basic three-byte program.
        clear_prog();
        add_byte(8'h41, 1'b0, 0);
        add_byte(8'h0A, 1'b0, 0);
        add_byte(8'hC3, 1'b1, 0);
        run_program(10, -1);

        // 70 bytes offered, never marked last: only 64 accepted.
        clear_prog();
        for (int i = 0; i < 70; i++) add_byte(8'($urandom), 1'b0, 0);
        run_program(4, -1);

        // valid pattern 1,0,1,1 with last on the third byte.
        clear_prog();
        add_byte(8'h11, 1'b0, 0);
        add_byte(8'h22, 1'b0, 1);
        add_byte(8'h33, 1'b1, 0);
        add_byte(8'h44, 1'b0, 0);
        run_program(3, -1);

        // Abort in RUN at cycle 5 of 100.
        clear_prog();
        add_byte(8'h5A, 1'b1, 0);
        run_program(100, 5);

        // Zero budget from DONE stays in DONE with err.
        run_budget = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("zb_done_state", 32'(state), 32'd4);
        check("zb_done_err", 32'(err), 32'd1);

        // Wrapping byte sum.
        clear_prog();
        add_byte(8'hFF, 1'b0, 0);
        add_byte(8'h02, 1'b1, 0);
        run_program(2, -1);

        // Randomized programs.
        for (int r = 0; r < 14; r++) begin
            clear_prog();
            cap_run   = ($urandom_range(0, 3) == 0);
            len       = cap_run ? $urandom_range(64, 70) : $urandom_range(1, 63);
            early_en  = ($urandom_range(0, 3) == 0);
            early_pos = $urandom_range(0, len - 1);
            for (int i = 0; i < len; i++) begin
                add_byte(8'($urandom),
                         (!cap_run && i == len - 1) || (early_en && i == early_pos),
                         ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
            end
            budget   = $urandom_range(1, 30);
            abort_at = (budget >= 2 && $urandom_range(0, 2) == 0) ?
                       $urandom_range(0, budget - 2) : -1;
            run_program(budget, abort_at);
        end

        // Asynchronous reset in the middle of a load.
        run_budget = 16'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        ld_if.valid = 1'b1;
        ld_if.data  = 8'h77;
        ld_if.last  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check_reset_values("mid_rst");
        ld_if.valid = 1'b0;
        #2;
        reset = 1'b1;
        tick();
        check("post_rst_state", 32'(state), 32'd0);
        check("post_rst_lcnt", 32'(load_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
